bufferoutput: RTL and testbench
===============================

Name: bufferoutput

Overview:
- Output-side counterpart of the input sample buffer in the multi-stream filter datapath.
- Accepts one DDWIDTH accumulator result per stream, in round-robin stream order, from the filter core.
- Each result is rounded and saturated to DWIDTH, then stored in a circular buffer.
- Results are emitted downstream with a stream tag over the same req/ack handshake.

Parameters:
- DWIDTH, 16, output sample width (signed).
- DDWIDTH, 2*DWIDTH, input accumulator width (signed).
- NR_STREAMS, 16, number of interleaved streams.
- NR_STREAMS_LOG, 4, log2(NR_STREAMS); width of the stream tag.
- FRAC_BITS, 15, fractional bits removed from the accumulator; must be >= 1.
- ADDR_BITS, 4, buffer address width; DEPTH = 2**ADDR_BITS entries.

Ports:
- clk, in, 1, single clock; all logic samples on the rising edge.
- rst, in, 1, synchronous active-low reset; rst=0 at a posedge resets the block.
- enable, in, 1, when 0 no new input is requested; buffered data keeps draining.
- req_in, out, 1, block ready to take a result.
- ack_in, in, 1, upstream presents valid data_in.
- data_in, in, DDWIDTH, signed accumulator result.
- req_out, out, 1, data_out/stream_out valid.
- ack_out, in, 1, downstream accepts data_out.
- data_out, out, DWIDTH, rounded and saturated sample.
- stream_out, out, NR_STREAMS_LOG, stream index of data_out.
- sat_flag, out, 1, sticky; set when any sample saturates.

Behaviour:
- Reset (rst=0 at a posedge), regardless of other inputs:
  - wr_ptr, rd_ptr and count go to 0; input and output stream counters go to 0.
  - req_out=0, data_out=0, stream_out=0, sat_flag=0.
  - Buffer contents are discarded.
  - Reset mid-transfer aborts the transfer: req_out is 0 in the cycle after the reset edge.
- req_in is combinational from registered state: req_in = rst & enable & (count != DEPTH).
- Input transfer happens at a posedge where req_in & ack_in:
  - conv(data_in) is written to mem[wr_ptr] together with the input stream counter value.
  - wr_ptr increments modulo DEPTH.
  - The input stream counter increments modulo NR_STREAMS (NR_STREAMS-1 wraps to 0).
- ack_in without req_in has no effect.
- conv(x):
  - t = sign-extended x (DDWIDTH+1 bits) + 2**(FRAC_BITS-1), i.e. round half up.
  - Arithmetic shift t right by FRAC_BITS.
  - Clamp the result to [-2**(DWIDTH-1), 2**(DWIDTH-1)-1].
  - If a clamp occurred, set sat_flag, which stays 1 until reset.
- Output register stage (data_out, stream_out, req_out):
  - The stage is free when req_out=0, or when req_out & ack_out at this edge.
  - If the stage is free and count != 0: load mem[rd_ptr], set req_out=1, increment rd_ptr modulo DEPTH.
  - If the stage is free and count = 0: req_out goes to 0; data_out and stream_out hold their last values.
  - While req_out & !ack_out, data_out, stream_out and req_out hold stable.
- Latency: a result accepted at edge N into an empty buffer gives req_out=1 after edge N+1.
- Sustained throughput: 1 sample per cycle with ack_out held at 1.
- count is the number of buffer entries, excluding the output register.
  - Simultaneous write and read in one cycle leaves count unchanged.
  - Full is count = DEPTH: req_in drops, and a write is never lost or overwritten.
  - Empty is count = 0: the output stage does not load.
  - Full plus a read in the same cycle: req_in rises in the following cycle, not the same one.
  - Pointer wrap from DEPTH-1 to 0 is seamless.
- enable=0 drops req_in in the same cycle; it does not affect the output side.

Test Plan:
- Reset then idle:
  - Stimulus: rst=0 for 2 cycles, then rst=1, enable=1, ack_in=0, ack_out=0.
  - Required: req_in=1, req_out=0, data_out=0, sat_flag=0.
- Single-sample latency and rounding:
  - Stimulus: data_in=32'h0000_C000 (1.5 at FRAC_BITS=15) accepted at edge N, ack_out=1.
  - Required: after edge N+1, req_out=1, data_out=16'h0002 (1.5 rounds to 2), stream_out=0; req_out=0 one cycle after it is consumed.
- Saturation:
  - Stimulus: data_in=32'h7FFF_FFFF, then 32'h8000_0000.
  - Required: data_out=16'h7FFF, then 16'h8000; sat_flag=1 and it stays set.
- Backpressure to full:
  - Stimulus: ack_out=0, feed 18 samples with ack_in held at 1.
  - Required: 17 transfers (16 in the buffer plus 1 in the output register), then req_in=0.
  - Then ack_out=1: samples emerge in order with stream_out 0..15,0 and no loss.
- Streaming wrap:
  - Stimulus: ack_in=ack_out=1 for 40 samples.
  - Required: 1 sample per cycle after 2-cycle fill; stream_out sequence 0..15,0..15,0..7; pointers wrap seamlessly.
- Reset mid-operation:
  - Stimulus: rst=0 while req_out=1 and count=5.
  - Required: after that edge req_out=0 and count=0; the next accepted sample carries stream_out=0.

Source files
------------

// File: rtl/bufferoutput.sv
// Output sample buffer: rounds/saturates filter accumulator results to DWIDTH,
// queues them with their stream tag and emits them over a req/ack handshake.
module bufferoutput #(
   parameter int DWIDTH         = 16,
   parameter int DDWIDTH        = 2 * DWIDTH,
   parameter int NR_STREAMS     = 16,
   parameter int NR_STREAMS_LOG = 4,
   parameter int FRAC_BITS      = 15,
   parameter int ADDR_BITS      = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enable,
   output logic                      req_in,
   input  logic                      ack_in,
   input  logic [DDWIDTH-1:0]        data_in,
   output logic                      req_out,
   input  logic                      ack_out,
   output logic [DWIDTH-1:0]         data_out,
   output logic [NR_STREAMS_LOG-1:0] stream_out,
   output logic                      sat_flag
);

   localparam int DEPTH = 2 ** ADDR_BITS;
   localparam logic [ADDR_BITS:0]          FULL_CNT    = (ADDR_BITS+1)'(DEPTH);
   localparam logic [ADDR_BITS:0]          CNT_ONE     = (ADDR_BITS+1)'(1);
   localparam logic [ADDR_BITS-1:0]        PTR_ONE     = ADDR_BITS'(1);
   localparam logic [NR_STREAMS_LOG-1:0]   LAST_STREAM = NR_STREAMS_LOG'(NR_STREAMS - 1);
   localparam logic [NR_STREAMS_LOG-1:0]   STREAM_ONE  = NR_STREAMS_LOG'(1);
   localparam logic signed [DDWIDTH:0]     RND_C       = (DDWIDTH+1)'(1) << (FRAC_BITS - 1);
   localparam logic signed [DDWIDTH:0]     SAT_MAX     = {{(DDWIDTH-DWIDTH+2){1'b0}}, {(DWIDTH-1){1'b1}}};
   localparam logic signed [DDWIDTH:0]     SAT_MIN     = {{(DDWIDTH-DWIDTH+2){1'b1}}, {(DWIDTH-1){1'b0}}};

   logic [DWIDTH-1:0]         mem_data_q [DEPTH];
   logic [NR_STREAMS_LOG-1:0] mem_strm_q [DEPTH];

   logic [ADDR_BITS-1:0]      wr_ptr_q, wr_ptr_d;
   logic [ADDR_BITS-1:0]      rd_ptr_q, rd_ptr_d;
   logic [ADDR_BITS:0]        count_q, count_d;
   logic [NR_STREAMS_LOG-1:0] in_strm_q, in_strm_d;
   logic                      req_out_q, req_out_d;
   logic [DWIDTH-1:0]         data_out_q, data_out_d;
   logic [NR_STREAMS_LOG-1:0] stream_out_q, stream_out_d;
   logic                      sat_flag_q, sat_flag_d;

   logic                      wr_en, rd_en, stage_free;
   logic signed [DDWIDTH:0]   ext, rnd, shd;
   logic [DWIDTH-1:0]         conv_data;
   logic                      conv_sat;

   assign req_in     = rst & enable & (count_q != FULL_CNT);
   assign wr_en      = req_in & ack_in;
   assign stage_free = ~req_out_q | ack_out;
   assign rd_en      = stage_free & (count_q != '0);

   // Extra sign bit keeps the round-half-up add from overflowing before the shift.
   always_comb begin
      ext       = {data_in[DDWIDTH-1], data_in};
      rnd       = ext + RND_C;
      shd       = rnd >>> FRAC_BITS;
      conv_data = shd[DWIDTH-1:0];
      conv_sat  = 1'b0;
      if (shd > SAT_MAX) begin
         conv_data = {1'b0, {(DWIDTH-1){1'b1}}};
         conv_sat  = 1'b1;
      end else if (shd < SAT_MIN) begin
         conv_data = {1'b1, {(DWIDTH-1){1'b0}}};
         conv_sat  = 1'b1;
      end
   end

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      in_strm_d    = in_strm_q;
      req_out_d    = req_out_q;
      data_out_d   = data_out_q;
      stream_out_d = stream_out_q;
      sat_flag_d   = sat_flag_q | (wr_en & conv_sat);

      if (wr_en) begin
         wr_ptr_d  = wr_ptr_q + PTR_ONE;
         in_strm_d = (in_strm_q == LAST_STREAM) ? '0 : in_strm_q + STREAM_ONE;
      end

      if (stage_free) begin
         req_out_d = rd_en;
         if (rd_en) begin
            data_out_d   = mem_data_q[rd_ptr_q];
            stream_out_d = mem_strm_q[rd_ptr_q];
            rd_ptr_d     = rd_ptr_q + PTR_ONE;
         end
      end

      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         in_strm_q    <= '0;
         req_out_q    <= 1'b0;
         data_out_q   <= '0;
         stream_out_q <= '0;
         sat_flag_q   <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         in_strm_q    <= in_strm_d;
         req_out_q    <= req_out_d;
         data_out_q   <= data_out_d;
         stream_out_q <= stream_out_d;
         sat_flag_q   <= sat_flag_d;
      end
   end

   // Storage needs no reset: entries are only read once count marks them valid.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_data_q[wr_ptr_q] <= conv_data;
         mem_strm_q[wr_ptr_q] <= in_strm_q;
      end
   end

   assign req_out    = req_out_q;
   assign data_out   = data_out_q;
   assign stream_out = stream_out_q;
   assign sat_flag   = sat_flag_q;

endmodule

// File: tb/tb_bufferoutput.sv
// Directed bench for bufferoutput: per-cycle vector table plus sequences for
// backpressure-to-full, streaming wrap and reset mid-operation.
module tb_bufferoutput;

   localparam int DW  = 16;
   localparam int DDW = 32;
   localparam int NS  = 16;
   localparam int NSL = 4;
   localparam int FB  = 15;
   localparam int AB  = 4;

   logic           clk = 1'b0;
   logic           rst, enable, ack_in, ack_out;
   logic           req_in, req_out, sat_flag;
   logic [DDW-1:0] data_in;
   logic [DW-1:0]  data_out;
   logic [NSL-1:0] stream_out;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bufferoutput #(
      .DWIDTH(DW), .DDWIDTH(DDW), .NR_STREAMS(NS),
      .NR_STREAMS_LOG(NSL), .FRAC_BITS(FB), .ADDR_BITS(AB)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .req_in(req_in), .ack_in(ack_in), .data_in(data_in),
      .req_out(req_out), .ack_out(ack_out), .data_out(data_out),
      .stream_out(stream_out), .sat_flag(sat_flag)
   );

   typedef struct {
      logic        rst, en, ai, ao;
      logic [31:0] din;
      logic        e_req_in, e_req_out;
      logic [15:0] e_dout;
      logic [3:0]  e_strm;
      logic        e_sat;
   } vec_t;

   vec_t vt [18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0; ack_in = 1'b0; ack_out = 1'b0; enable = 1'b1; data_in = '0;
      tick();
      rst = 1'b1;
   endtask

   initial begin
      int n, got, first, last;
      // rst en ai ao din | req_in | req_out dout strm sat
      vt[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0};
      vt[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0};
      vt[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 16'h0000, 4'd0, 1'b0};
      vt[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_C000, 1'b1, 1'b0, 16'h0000, 4'd0, 1'b0};
      vt[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 16'h0002, 4'd0, 1'b0};
      vt[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 16'h0002, 4'd0, 1'b0};
      vt[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, 16'h0002, 4'd0, 1'b1};
      vt[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 16'h7FFF, 4'd1, 1'b1};
      vt[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 16'h8000, 4'd2, 1'b1};
      vt[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 16'h8000, 4'd2, 1'b1};
      vt[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_C000, 1'b1, 1'b0, 16'h8000, 4'd2, 1'b1};
      vt[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_BFFF, 1'b1, 1'b1, 16'h0000, 4'd3, 1'b1};
      vt[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 16'hFFFF, 4'd4, 1'b1};
      vt[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 16'hFFFF, 4'd4, 1'b1};
      vt[14] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 16'hFFFF, 4'd4, 1'b1};
      vt[15] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0001_0000, 1'b1, 1'b0, 16'hFFFF, 4'd4, 1'b1};
      vt[16] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 16'h0002, 4'd5, 1'b1};
      vt[17] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 16'h0002, 4'd5, 1'b1};

      rst = 1'b0; enable = 1'b1; ack_in = 1'b0; ack_out = 1'b0; data_in = '0;
      #1;
      for (int i = 0; i < 18; i++) begin
         rst = vt[i].rst; enable = vt[i].en; ack_in = vt[i].ai;
         ack_out = vt[i].ao; data_in = vt[i].din;
         #1;
         check($sformatf("vec%0d_req_in", i), 32'(req_in), 32'(vt[i].e_req_in));
         tick();
         check($sformatf("vec%0d_req_out", i), 32'(req_out), 32'(vt[i].e_req_out));
         check($sformatf("vec%0d_data_out", i), 32'(data_out), 32'(vt[i].e_dout));
         check($sformatf("vec%0d_stream_out", i), 32'(stream_out), 32'(vt[i].e_strm));
         check($sformatf("vec%0d_sat_flag", i), 32'(sat_flag), 32'(vt[i].e_sat));
      end

      // Backpressure until full, then drain in order.
      do_reset();
      ack_out = 1'b0; ack_in = 1'b1; n = 0;
      for (int i = 0; i < 18; i++) begin
         data_in = 32'(n) << 15;
         #1;
         if (req_in) n++;
         tick();
      end
      ack_in = 1'b0;
      #1;
      check("bp_transfers", 32'(n), 32'd17);
      check("bp_req_in_full", 32'(req_in), 32'd0);
      check("bp_req_out_held", 32'(req_out), 32'd1);
      ack_out = 1'b1; got = 0;
      for (int c = 0; c < 40 && got < 17; c++) begin
         if (req_out) begin
            check($sformatf("bp_data%0d", got), 32'(data_out), 32'(got));
            check($sformatf("bp_strm%0d", got), 32'(stream_out), 32'(got % NS));
            got++;
         end
         tick();
      end
      check("bp_drained", 32'(got), 32'd17);
      check("bp_req_out_empty", 32'(req_out), 32'd0);

      // Streaming with both handshakes held high; 40 samples across pointer wraps.
      do_reset();
      ack_out = 1'b1; n = 0; got = 0; first = -1; last = -1;
      for (int c = 0; c < 60 && got < 40; c++) begin
         ack_in = (n < 40);
         data_in = 32'(n) << 15;
         #1;
         if (n < 40) check($sformatf("st_req_in%0d", n), 32'(req_in), 32'd1);
         if (req_out) begin
            if (first < 0) first = c;
            last = c;
            check($sformatf("st_data%0d", got), 32'(data_out), 32'(got));
            check($sformatf("st_strm%0d", got), 32'(stream_out), 32'(got % NS));
            got++;
         end
         if (ack_in && req_in) n++;
         tick();
      end
      ack_in = 1'b0;
      check("st_count", 32'(got), 32'd40);
      check("st_first_cycle", 32'(first), 32'd2);
      check("st_rate", 32'(last - first), 32'd39);

      // Reset while the output register is loaded and five entries are queued.
      do_reset();
      ack_out = 1'b0; ack_in = 1'b1;
      for (int i = 0; i < 6; i++) begin
         data_in = 32'(i + 100) << 15;
         tick();
      end
      ack_in = 1'b0;
      check("rm_req_out_before", 32'(req_out), 32'd1);
      check("rm_data_before", 32'(data_out), 32'd100);
      rst = 1'b0; ack_in = 1'b1;
      tick();
      check("rm_req_out_after", 32'(req_out), 32'd0);
      check("rm_data_after", 32'(data_out), 32'd0);
      rst = 1'b1; ack_in = 1'b0; ack_out = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("rm_empty%0d", i), 32'(req_out), 32'd0);
      end
      ack_in = 1'b1; data_in = 32'd7 << 15;
      tick();
      ack_in = 1'b0;
      got = 0;
      for (int c = 0; c < 5 && got == 0; c++) begin
         tick();
         if (req_out) begin
            got = 1;
            check("rm_next_data", 32'(data_out), 32'd7);
            check("rm_next_strm", 32'(stream_out), 32'd0);
         end
      end
      check("rm_next_seen", 32'(got), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
